// File: rtl/tank_pkg.sv
// Shared types and screen constants for the tank game datapath.
package tank_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int TANK_SIZE = 32;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
        dir_t       dir;
    } bullet_t;

endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: loads at the muzzle, steps once per frame tick and
// retires itself when the next step would leave the screen.
module bullet_slot #(
    parameter int BULLET_SIZE = 4,
    parameter int SPEED       = 4,
    parameter int SCREEN_W    = tank_pkg::SCREEN_W,
    parameter int SCREEN_H    = tank_pkg::SCREEN_H
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              tick,
    input  logic              load,
    input  tank_pkg::bullet_t load_val,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              active,
    output logic              active_next,
    output logic              hit
);

    localparam logic [10:0] SPD   = 11'(SPEED);
    localparam logic [9:0]  SPD10 = 10'(SPEED);
    localparam logic [10:0] BSZ   = 11'(BULLET_SIZE);
    localparam logic [10:0] MAX_X = 11'(SCREEN_W);
    localparam logic [10:0] MAX_Y = 11'(SCREEN_H);

    tank_pkg::bullet_t b, b_next;
    logic [10:0] x_ext, y_ext, px_ext, py_ext;

    assign x_ext  = {1'b0, b.x};
    assign y_ext  = {1'b0, b.y};
    assign px_ext = {1'b0, DrawX};
    assign py_ext = {1'b0, DrawY};

    // A freshly loaded bullet does not move on its spawn tick.
    always_comb begin
        b_next = b;
        if (tick) begin
            if (load) begin
                b_next = load_val;
            end else if (b.active) begin
                case (b.dir)
                    tank_pkg::DIR_UP:
                        if (y_ext < SPD) b_next.active = 1'b0;
                        else             b_next.y = b.y - SPD10;
                    tank_pkg::DIR_DOWN:
                        if (y_ext + SPD + BSZ > MAX_Y) b_next.active = 1'b0;
                        else                           b_next.y = b.y + SPD10;
                    tank_pkg::DIR_LEFT:
                        if (x_ext < SPD) b_next.active = 1'b0;
                        else             b_next.x = b.x - SPD10;
                    tank_pkg::DIR_RIGHT:
                        if (x_ext + SPD + BSZ > MAX_X) b_next.active = 1'b0;
                        else                           b_next.x = b.x + SPD10;
                    default:
                        b_next.active = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            b <= '{active: 1'b0, x: 10'd0, y: 10'd0, dir: tank_pkg::DIR_UP};
        end else begin
            b <= b_next;
        end
    end

    assign active      = b.active;
    assign active_next = b_next.active;
    assign hit = b.active
               && (px_ext >= x_ext) && (px_ext < x_ext + BSZ)
               && (py_ext >= y_ext) && (py_ext < y_ext + BSZ);

endmodule

// File: rtl/bullet_engine.sv
// Bullet pool for the tank: frame tick detect, spawn allocation, cooldown and
// pixel hit merge. Define BULLET_EDGE_FIRE_EN to require a fire release between shots.
module bullet_engine #(
    parameter int NUM_BULLETS     = 4,
    parameter int BULLET_SIZE     = 4,
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int TANK_SIZE       = tank_pkg::TANK_SIZE,
    parameter int SCREEN_W        = tank_pkg::SCREEN_W,
    parameter int SCREEN_H        = tank_pkg::SCREEN_H
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] tank_X,
    input  logic [9:0] tank_Y,
    input  logic [2:0] tank_dir,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_bullet,
    output logic [2:0] bullet_count,
    output logic       fire_ack
);

    localparam int          CD_W   = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [11:0] BS12   = 12'(BULLET_SIZE);
    localparam logic [11:0] TS12   = 12'(TANK_SIZE);
    localparam logic [11:0] HALF12 = 12'(TANK_SIZE / 2 - BULLET_SIZE / 2);
    localparam logic [11:0] W12    = 12'(SCREEN_W);
    localparam logic [11:0] H12    = 12'(SCREEN_H);

    logic                   frame_q, tick, spawn, fire_ok;
    logic                   free_found, dir_ok, underflow, muzzle_ok;
    logic [NUM_BULLETS-1:0] slot_active, slot_active_next, slot_hit, free_sel, slot_load;
    logic [11:0]            tx, ty, mx, my;
    logic [CD_W-1:0]        cooldown;
    logic [2:0]             count_next;
    tank_pkg::bullet_t      load_val;

    always_ff @(posedge Clk) begin
        if (Reset) frame_q <= 1'b0;
        else       frame_q <= frame_clk;
    end
    assign tick = frame_clk & ~frame_q;

    // Allocation sees occupancy before this tick's retirements.
    always_comb begin
        free_found = 1'b0;
        free_sel   = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!slot_active[i] && !free_found) begin
                free_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    always_comb begin
        tx        = {2'b00, tank_X};
        ty        = {2'b00, tank_Y};
        mx        = tx + HALF12;
        my        = ty + HALF12;
        dir_ok    = 1'b1;
        underflow = 1'b0;
        case (tank_dir)
            tank_pkg::DIR_UP: begin
                my        = ty - BS12;
                underflow = (ty < BS12);
            end
            tank_pkg::DIR_DOWN:  my = ty + TS12;
            tank_pkg::DIR_LEFT: begin
                mx        = tx - BS12;
                underflow = (tx < BS12);
            end
            tank_pkg::DIR_RIGHT: mx = tx + TS12;
            default:             dir_ok = 1'b0;
        endcase
        muzzle_ok = dir_ok && !underflow && (mx + BS12 <= W12) && (my + BS12 <= H12);
    end

    always_comb begin
        load_val.active = 1'b1;
        load_val.x      = mx[9:0];
        load_val.y      = my[9:0];
        load_val.dir    = tank_pkg::dir_t'(tank_dir);
    end

`ifdef BULLET_EDGE_FIRE_EN
    logic released;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            released <= 1'b0;
        end else if (tick) begin
            if (spawn)      released <= 1'b0;
            else if (!fire) released <= 1'b1;
        end
    end
    assign fire_ok = released;
`else
    assign fire_ok = 1'b1;
`endif

    assign spawn     = tick && fire && fire_ok && (cooldown == '0) && free_found && muzzle_ok;
    assign slot_load = spawn ? free_sel : '0;

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .BULLET_SIZE (BULLET_SIZE),
            .SPEED       (SPEED),
            .SCREEN_W    (SCREEN_W),
            .SCREEN_H    (SCREEN_H)
        ) u_slot (
            .Clk         (Clk),
            .Reset       (Reset),
            .tick        (tick),
            .load        (slot_load[g]),
            .load_val    (load_val),
            .DrawX       (DrawX),
            .DrawY       (DrawY),
            .active      (slot_active[g]),
            .active_next (slot_active_next[g]),
            .hit         (slot_hit[g])
        );
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            count_next = count_next + 3'(slot_active_next[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cooldown     <= '0;
            fire_ack     <= 1'b0;
            bullet_count <= 3'd0;
        end else begin
            fire_ack     <= spawn;
            bullet_count <= count_next;
            if (tick) begin
                if (spawn)                cooldown <= CD_W'(COOLDOWN_FRAMES);
                else if (cooldown != '0)  cooldown <= cooldown - CD_W'(1);
            end
        end
    end

    assign is_bullet = |slot_hit;

endmodule

// File: tb/tb_bullet_engine.sv
// Randomized bench for bullet_engine against a frame-level pool model;
// follows BULLET_EDGE_FIRE_EN when it is defined.
module tb_bullet_engine;

    localparam int NB = 4;

    logic       Clk, Reset, frame_clk, fire;
    logic [9:0] tank_X, tank_Y, DrawX, DrawY;
    logic [2:0] tank_dir;
    logic       is_bullet, fire_ack;
    logic [2:0] bullet_count;

    int checks = 0;
    int passed = 0;

    int m_act[NB], m_x[NB], m_y[NB], m_dir[NB];
    int m_cd, m_released, m_spawned;

    bullet_engine dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .fire         (fire),
        .tank_X       (tank_X),
        .tank_Y       (tank_Y),
        .tank_dir     (tank_dir),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .is_bullet    (is_bullet),
        .bullet_count (bullet_count),
        .fire_ack     (fire_ack)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected)
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        else
            passed++;
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < NB; i++) n += m_act[i];
        return n;
    endfunction

    function automatic int modelHit(input int px, input int py);
        for (int i = 0; i < NB; i++)
            if (m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + 4 && py >= m_y[i] && py < m_y[i] + 4)
                return 1;
        return 0;
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < NB; i++) m_act[i] = 0;
        m_cd = 0;
        m_released = 0;
    endfunction

    // Frame-level behaviour: move existing bullets, then maybe spawn at the muzzle.
    function automatic void modelTick(input int f, input int tx, input int ty, input int td);
        int free_slot = -1;
        int mx = 0, my = 0;
        int ok = 1;
        int can;
        for (int i = NB - 1; i >= 0; i--) if (m_act[i] == 0) free_slot = i;
        case (td)
            1: begin mx = tx + 14; my = ty - 4;  end
            4: begin mx = tx + 14; my = ty + 32; end
            3: begin mx = tx - 4;  my = ty + 14; end
            2: begin mx = tx + 32; my = ty + 14; end
            default: ok = 0;
        endcase
        if (mx < 0 || my < 0 || mx + 4 > 640 || my + 4 > 480) ok = 0;
        can = (f != 0 && m_cd == 0 && ok != 0 && free_slot >= 0) ? 1 : 0;
`ifdef BULLET_EDGE_FIRE_EN
        if (m_released == 0) can = 0;
`endif
        for (int i = 0; i < NB; i++) begin
            if (m_act[i] != 0) begin
                case (m_dir[i])
                    1: if (m_y[i] < 4) m_act[i] = 0; else m_y[i] -= 4;
                    4: if (m_y[i] + 8 > 480) m_act[i] = 0; else m_y[i] += 4;
                    3: if (m_x[i] < 4) m_act[i] = 0; else m_x[i] -= 4;
                    default: if (m_x[i] + 8 > 640) m_act[i] = 0; else m_x[i] += 4;
                endcase
            end
        end
        if (can != 0) begin
            m_act[free_slot] = 1;
            m_x[free_slot]   = mx;
            m_y[free_slot]   = my;
            m_dir[free_slot] = td;
            m_cd = 15;
            m_released = 0;
        end else begin
            if (m_cd > 0) m_cd--;
            if (f == 0) m_released = 1;
        end
        m_spawned = can;
    endfunction

    task automatic probeOne(input string tag, input int px, input int py);
        DrawX = 10'(px);
        DrawY = 10'(py);
        #1;
        checkOutput(tag, int'(is_bullet), modelHit(px, py));
    endtask

    task automatic probePixels();
        for (int i = 0; i < NB; i++) begin
            if (m_act[i] != 0) begin
                probeOne("hit_in", m_x[i] + $urandom_range(0, 3), m_y[i] + $urandom_range(0, 3));
                probeOne("hit_edge", m_x[i] + 4, m_y[i]);
            end
        end
        probeOne("hit_rand", $urandom_range(0, 639), $urandom_range(0, 479));
    endtask

    // One frame: raise frame_clk for two Clk cycles, then check ack pulse, count and pixels.
    task automatic applyStimulus(input int f, input int tx, input int ty, input int td);
        @(negedge Clk);
        fire      = (f != 0);
        tank_X    = 10'(tx);
        tank_Y    = 10'(ty);
        tank_dir  = 3'(td);
        frame_clk = 1'b1;
        @(negedge Clk);
        modelTick(f, tx, ty, td);
        checkOutput("fire_ack", int'(fire_ack), m_spawned);
        checkOutput("bullet_count", int'(bullet_count), modelCount() % 8);
        @(negedge Clk);
        frame_clk = 1'b0;
        checkOutput("fire_ack_pulse", int'(fire_ack), 0);
        checkOutput("count_hold", int'(bullet_count), modelCount() % 8);
        probePixels();
    endtask

    task automatic doReset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        modelClear();
        checkOutput("reset_count", int'(bullet_count), 0);
        checkOutput("reset_ack", int'(fire_ack), 0);
        probePixels();
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; fire = 1'b0;
        tank_X = '0; tank_Y = '0; tank_dir = '0; DrawX = '0; DrawY = '0;
        modelClear();
        repeat (2) @(negedge Clk);
        doReset();

        // Single shot up from (500,240), then one step.
        applyStimulus(1, 500, 240, 1);
        applyStimulus(0, 500, 240, 1);
        probeOne("tp_in", 514, 232);
        probeOne("tp_corner", 517, 235);
        probeOne("tp_out", 518, 232);

        // Held fire to the right, preceded by one released frame.
        doReset();
        applyStimulus(0, 100, 100, 2);
        repeat (40) applyStimulus(1, 100, 100, 2);

        // Pool saturation, then reuse of the freed lowest slot.
        doReset();
        repeat (140) applyStimulus(1, 100, 100, 2);

        // Upward bullet near the top edge retires.
        doReset();
        applyStimulus(0, 300, 30, 1);
        applyStimulus(1, 300, 30, 1);
        repeat (10) applyStimulus(0, 300, 30, 1);

        // Suppressed spawns: muzzle above the screen and an invalid direction.
        doReset();
        applyStimulus(0, 300, 2, 1);
        applyStimulus(1, 300, 2, 1);
        applyStimulus(1, 300, 2, 5);
        applyStimulus(1, 300, 2, 0);

        // Random frames, then reset with bullets in flight.
        for (int n = 0; n < 300; n++)
            applyStimulus(($urandom_range(0, 3) != 0) ? 1 : 0,
                          $urandom_range(0, 639), $urandom_range(0, 479),
                          $urandom_range(0, 6));
        doReset();

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bullet_engine.md
Name: bullet_engine

Overview:
- Projectile stage directly downstream of the keyboard-driven tank controller.
- Consumes the tank's position, facing direction and shooting request; owns a fixed pool of bullets.
- Spawns bullets at the muzzle, advances them once per frame, and retires them at the screen edge.
- Drives a per-pixel is_bullet flag to the colour mapper.

Parameters:
- NUM_BULLETS, 4, pool size (1–8)
- BULLET_SIZE, 4, bullet square side in pixels
- SPEED, 4, pixels moved per frame
- COOLDOWN_FRAMES, 15, frames blocked after a successful spawn
- TANK_SIZE, 32, tank square side, used for the muzzle offset
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  ~60 Hz frame strobe (vsync domain, sampled on Clk)
- fire  in  1  tank shooting request, level
- tank_X  in  10  tank top-left X
- tank_Y  in  10  tank top-left Y
- tank_dir  in  3  facing: 1 up, 2 right, 3 left, 4 down; other codes invalid
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- is_bullet  out  1  current pixel lies inside any active bullet
- bullet_count  out  3  number of active slots, registered
- fire_ack  out  1  one-Clk pulse on a successful spawn

Behaviour:
- Reset: synchronous, active-high; Clk is the only clock.
  - Reset clears all slots inactive and sets cooldown=0, bullet_count=0, fire_ack=0, is_bullet=0.
  - Reset asserted mid-flight clears the pool on the next Clk edge; no bullets survive.
- Frame tick: frame_clk is registered once; tick = rising edge, a one-Clk pulse. All state updates happen only on tick cycles.
- Per-slot state: active, x[9:0], y[9:0], dir[2:0].
- Motion, applied on tick to each active slot (11-bit unsigned arithmetic, no wrap):
  - up: if y < SPEED, retire; else y -= SPEED.
  - down: if y+SPEED+BULLET_SIZE > SCREEN_H, retire; else y += SPEED.
  - left: if x < SPEED, retire; else x -= SPEED.
  - right: if x+SPEED+BULLET_SIZE > SCREEN_W, retire; else x += SPEED.
- Spawn, on tick: condition is fire=1, cooldown=0, tank_dir valid and at least one slot free (evaluated before this tick's retirements).
  - The lowest-index free slot is loaded with the muzzle position:
    - up: (tank_X+TANK_SIZE/2-BULLET_SIZE/2, tank_Y-BULLET_SIZE)
    - down: (same X, tank_Y+TANK_SIZE)
    - left: (tank_X-BULLET_SIZE, tank_Y+TANK_SIZE/2-BULLET_SIZE/2)
    - right: (tank_X+TANK_SIZE, same Y)
  - If the muzzle position underflows or the bullet would extend past the screen, the spawn is suppressed: no slot load, cooldown unchanged, no fire_ack.
  - The new bullet is not moved on its spawn tick.
  - A slot retiring on this tick is not reusable until the next tick.
- Cooldown:
  - Loaded with COOLDOWN_FRAMES on a successful spawn.
  - Otherwise decremented on each tick while non-zero.
  - With fire held continuously, spawns occur every COOLDOWN_FRAMES+1 ticks.
- fire_ack: asserted exactly on the Clk cycle following the spawn tick.
- bullet_count: updated the cycle after the tick, reflecting both spawns and retirements.
- is_bullet: combinational OR over active slots of (x ≤ DrawX < x+BULLET_SIZE) and (y ≤ DrawY < y+BULLET_SIZE).

Optional Feature:
- Macro: BULLET_EDGE_FIRE_EN.
- Defined: a spawn additionally requires fire to have been sampled 0 on some tick since the last spawn, so holding fire yields a single shot. The "released" flag is cleared on reset.
- Undefined: holding fire auto-repeats at the cooldown rate.

Decomposition:
- Shared package tank_pkg:
  - dir_t enum (DIR_UP=1, DIR_RIGHT=2, DIR_LEFT=3, DIR_DOWN=4).
  - SCREEN_W/SCREEN_H/TANK_SIZE constants.
  - bullet_t struct {active, x, y, dir}.
- Sub-module bullet_slot, instantiated NUM_BULLETS times:
  - Holds one bullet_t.
  - Handles load, motion and retirement on tick.
  - Outputs active and pixel-hit.
- The top level handles tick detect, slot allocation, cooldown, count and the OR-reduction.

Test Plan:
- Tank (500,240), dir=1, fire pulsed across one tick -> fire_ack next cycle; slot0 at (514,236); next tick y=232; is_bullet=1 at (514..517, 232..235), 0 at DrawX=518.
- fire held 40 ticks, dir=2, tank (100,100), other parameters default -> spawns on ticks 0, 16, 32 only; bullet_count reaches 3.
- Bullet dir=1 at y=2 -> retired on next tick; bullet_count decrements; is_bullet never asserts above y=0.
- 4 active bullets, fire=1, cooldown=0 -> no spawn, no fire_ack, cooldown stays 0; first tick after a retirement spawns into the freed (lowest) slot.
- Tank (300,2), dir=1 (muzzle Y=-2), and separately dir=5 -> no spawn, cooldown stays 0; Reset asserted with 3 bullets in flight -> bullet_count=0 and is_bullet=0 next cycle.
- BULLET_EDGE_FIRE_EN defined, fire held 50 ticks -> exactly one spawn; drop fire for one tick, raise again after cooldown -> second spawn.
